seq_game_engine: RTL and testbench
==================================

SEQ_GAME_ENGINE -- requirements
Module: seq_game_engine

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 4, giving the number of keys/LEDs; legal values are 2, 4 and 8.
REQ-002 The block SHALL have parameter MAX_ROUNDS, default 16, giving the sequence buffer depth; legal range is 1..64.
REQ-003 The block SHALL have parameter TICK_DIV, default 50_000_000, giving clock cycles per game tick.
REQ-004 The block SHALL have parameter TIMEOUT_TICKS, default 5, giving the number of ticks without a press before the player loses.
REQ-005 The block SHALL derive SW = clog2(N_KEYS) and RW = clog2(MAX_ROUNDS+1) from the parameters.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset, with the ports named as follows:
- clock_50  in  1  system clock.
- reset  in  1  asynchronous, active-high.
REQ-007 The remaining ports SHALL be:
- start  in  1  one-cycle start pulse.
- level  in  2  speed level, 0 = slowest.
- seed  in  8  LFSR seed (map select).
- max_rounds  in  RW  rounds needed to win.
- key_pulse  in  N_KEYS  synchronised one-cycle key pulses.
- leds  out  N_KEYS  one-hot sequence display.
- round  out  RW  current round, 1-based.
- points  out  8  score.
- busy  out  1  game in progress.
- win  out  1  game won (held).
- lose  out  1  game lost (held).

Function
REQ-008 The state machine SHALL have the states IDLE, SHOW_ON, SHOW_OFF, WAIT_USER, WIN and LOSE.
REQ-009 A start pulse in IDLE, WIN or LOSE SHALL do all of the following, and the FSM SHALL enter SHOW_ON on the next edge:
- load the LFSR with seed, using 8'h01 if seed is 0;
- set round to 1 and points to 0;
- clear win and lose;
- generate symbol 0 into the buffer.
REQ-010 A start pulse SHALL be ignored while busy is 1.
REQ-011 Symbol generation SHALL advance the 8-bit Fibonacci LFSR once, then store lfsr[SW-1:0]:
- shift left;
- new bit = l[7]^l[5]^l[4]^l[3].
REQ-012 The tick prescaler SHALL clear on every state transition, so each tick is exactly TICK_DIV cycles after state entry.
REQ-013 SHOW_ON SHALL drive leds = onehot(buf[step]) for 2^(3-level) ticks, then enter SHOW_OFF.
REQ-014 SHOW_OFF SHALL drive leds = 0 for 2^(3-level) ticks, then increment step and act as follows:
- if step equals round, clear step and enter WAIT_USER;
- otherwise, return to SHOW_ON.
REQ-015 In WAIT_USER, leds SHALL be 0, and a nonzero key_pulse SHALL be handled as follows:
- more than one bit set -> LOSE;
- one-hot value not equal to onehot(buf[step]) -> LOSE;
- correct and step+1 < round -> increment step and restart the timeout.
REQ-016 A correct final press of a round SHALL add (level+1) to points, saturating at 255, and then:
- if round equals the effective maximum, enter WIN;
- otherwise, increment round, generate the next symbol into buf[round-1], clear step and enter SHOW_ON.
REQ-017 The effective maximum SHALL be max_rounds, with 0 or values above MAX_ROUNDS treated as MAX_ROUNDS.
REQ-018 TIMEOUT_TICKS ticks in WAIT_USER with no press SHALL cause a transition to LOSE.
REQ-019 A key pulse SHALL be ignored in every state except WAIT_USER.
REQ-020 A key pulse coinciding with the timeout tick SHALL be evaluated and the timeout SHALL NOT fire.
REQ-021 In WIN and LOSE, round and points SHALL hold, and the state SHALL persist until the next start pulse.
REQ-022 busy SHALL be 1 exactly in SHOW_ON, SHOW_OFF and WAIT_USER.
REQ-023 All outputs SHALL be registered.
REQ-024 leds SHALL change on the same edge as the state it belongs to.

Reset
REQ-025 Assertion of reset SHALL immediately force the following, from any state including mid-show:
- state = IDLE;
- leds = 0, round = 0, points = 0;
- busy = 0, win = 0, lose = 0;
- LFSR = 8'h01, prescaler = 0.
REQ-026 Buffer contents SHALL NOT require a reset.

Structure
REQ-027 Package seq_game_pkg SHALL hold the following shared definitions:
- the state enum;
- the LFSR tap mask 8'hB8;
- the default seed 8'h01;
- a onehot function;
- the saturating-add constant 255.
REQ-028 The LFSR SHALL be sub-module seq_lfsr, with ports clock_50, reset, load, seed, step and q.
REQ-029 The sequence buffer SHALL be an internal array of MAX_ROUNDS x SW bits.

Verification
REQ-030 The bench SHALL use TICK_DIV = 4 and N_KEYS = 4 in all scenarios.
REQ-031 The bench SHALL cover at least the following directed scenarios:
- Win: seed 8'h01, level 3, max_rounds 2, start. Round 1 shows leds 4'b0100 for 4 cycles; press key 2. Round 2 shows 2, then 0; press 2, then 0. Required response: win = 1, points = 8, round = 2, busy = 0.
- Wrong key: same setup; in round 1 press key 1. Required response: lose = 1 on the next edge, points = 0, round = 1.
- Timeout: TIMEOUT_TICKS = 5; no press in WAIT_USER. Required response: lose asserts exactly 20 cycles after WAIT_USER entry.
- Double key: key_pulse = 4'b0101 in WAIT_USER. Required response: lose = 1.
- Reset mid-show: assert reset during SHOW_ON of round 2. Required response: all outputs 0 and state IDLE immediately; a subsequent start replays symbol 2 first.
- max_rounds = 0 with MAX_ROUNDS = 3: play 3 correct rounds (symbols 2, 0, 0). Required response: win after round 3, points = 12.

Source files
------------

// File: rtl/seq_game_pkg.sv
// Shared definitions for the sequence-memory game engine.
//   state_t       : game FSM states
//   LFSR_TAPS     : feedback taps of the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   DEFAULT_SEED  : LFSR value used when the seed is zero (an all-zero LFSR locks up)
//   POINTS_MAX    : score saturation value
//   onehot()      : symbol index -> one-hot key/LED pattern (8 bits, callers truncate)
//   lfsr_next()   : one LFSR advance (shift left, XOR of taps enters at bit 0)
//   seed_fix()    : substitutes DEFAULT_SEED for a zero seed
package seq_game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHOW_ON   = 3'd1,
        SHOW_OFF  = 3'd2,
        WAIT_USER = 3'd3,
        WIN       = 3'd4,
        LOSE      = 3'd5
    } state_t;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h01;
    localparam logic [7:0] POINTS_MAX   = 8'd255;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/seq_lfsr.sv
// 8-bit Fibonacci LFSR used to draw game symbols.
//   clock_50 : clock
//   reset    : asynchronous active-high reset, loads DEFAULT_SEED
//   load     : load seed (zero replaced by DEFAULT_SEED) and advance once,
//              so the register already holds the value that produced symbol 0
//   seed     : seed value
//   step     : advance once (one new symbol drawn)
//   q        : current LFSR value
module seq_lfsr
    import seq_game_pkg::*;
(
    input  logic       clock_50,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            q <= DEFAULT_SEED;
        end else if (load) begin
            q <= lfsr_next(seed_fix(seed));
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/seq_game_engine.sv
// Sequence-memory ("Simon") game engine.
// Shows a growing random sequence on one-hot LEDs, then checks the player's
// key presses against it. Every round won adds (level+1) points.
// Ports:
//   clock_50   : clock
//   reset      : asynchronous active-high reset
//   start      : one-cycle start pulse (ignored while busy)
//   level      : speed level, each phase lasts 2^(3-level) ticks
//   seed       : LFSR seed, selects the sequence
//   max_rounds : rounds needed to win (0 or > MAX_ROUNDS means MAX_ROUNDS)
//   key_pulse  : one-cycle key pulses, one bit per key
//   leds       : one-hot sequence display
//   round      : current round, 1-based
//   points     : saturating score
//   busy       : game in progress
//   win/lose   : held result flags
//   state_dbg  : current FSM state
module seq_game_engine
    import seq_game_pkg::*;
#(
    parameter  int N_KEYS        = 4,
    parameter  int MAX_ROUNDS    = 16,
    parameter  int TICK_DIV      = 50_000_000,
    parameter  int TIMEOUT_TICKS = 5,
    localparam int SW            = $clog2(N_KEYS),
    localparam int RW            = $clog2(MAX_ROUNDS + 1)
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        level,
    input  logic [7:0]        seed,
    input  logic [RW-1:0]     max_rounds,
    input  logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] leds,
    output logic [RW-1:0]     round,
    output logic [7:0]        points,
    output logic              busy,
    output logic              win,
    output logic              lose,
    output state_t            state_dbg
);

    localparam int AW   = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
    localparam int PW   = $clog2(TICK_DIV + 1);
    localparam int TMAX = (TIMEOUT_TICKS > 8) ? TIMEOUT_TICKS : 8;
    localparam int TW   = $clog2(TMAX + 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q;
    logic [TW-1:0]     tcnt_q;
    logic [RW-1:0]     step_q, step_d;
    logic [RW-1:0]     round_q;
    logic [7:0]        points_q;
    logic [7:0]        lfsr_q;
    logic [SW-1:0]     seq_buf [MAX_ROUNDS];

    logic              tick, show_done, timeout_done;
    logic [TW-1:0]     show_len;
    logic [RW-1:0]     max_eff;
    logic [SW-1:0]     gen_sym, exp_sym, show_sym;
    logic [N_KEYS-1:0] exp_keys, leds_d;
    logic [8:0]        points_sum;
    logic              do_start, adv_round, round_done, restart;

    seq_lfsr u_lfsr (
        .clock_50 (clock_50),
        .reset    (reset),
        .load     (do_start),
        .seed     (seed),
        .step     (adv_round),
        .q        (lfsr_q)
    );

    // Next FSM state plus the one-cycle actions that go with each transition.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        do_start     = 1'b0;
        adv_round    = 1'b0;
        round_done   = 1'b0;
        restart      = 1'b0;

        tick         = (presc_q == PW'(TICK_DIV - 1));
        show_len     = TW'(8'd1 << (2'd3 - level));
        show_done    = tick && (tcnt_q == show_len - TW'(1));
        timeout_done = tick && (tcnt_q == TW'(TIMEOUT_TICKS - 1));
        max_eff      = (max_rounds == '0 || max_rounds > RW'(MAX_ROUNDS))
                       ? RW'(MAX_ROUNDS) : max_rounds;
        exp_sym      = seq_buf[step_q[AW-1:0]];
        exp_keys     = N_KEYS'(onehot(3'(exp_sym)));

        case (state_q)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    do_start = 1'b1;
                    step_d   = '0;
                    state_d  = SHOW_ON;
                end
            end
            SHOW_ON: begin
                if (show_done) state_d = SHOW_OFF;
            end
            SHOW_OFF: begin
                if (show_done) begin
                    if (step_q + RW'(1) == round_q) begin
                        step_d  = '0;
                        state_d = WAIT_USER;
                    end else begin
                        step_d  = step_q + RW'(1);
                        state_d = SHOW_ON;
                    end
                end
            end
            WAIT_USER: begin
                // A press wins over a coinciding timeout tick.
                if (key_pulse != '0) begin
                    if ((key_pulse & (key_pulse - N_KEYS'(1))) != '0) begin
                        state_d = LOSE;
                    end else if (key_pulse != exp_keys) begin
                        state_d = LOSE;
                    end else if (step_q + RW'(1) < round_q) begin
                        step_d  = step_q + RW'(1);
                        restart = 1'b1;
                    end else begin
                        round_done = 1'b1;
                        if (round_q == max_eff) begin
                            state_d = WIN;
                        end else begin
                            adv_round = 1'b1;
                            step_d    = '0;
                            state_d   = SHOW_ON;
                        end
                    end
                end else if (timeout_done) begin
                    state_d = LOSE;
                end
            end
            default: state_d = IDLE;
        endcase

        // On start the new symbol 0 is written this edge, so bypass the buffer.
        gen_sym    = SW'(lfsr_next(do_start ? seed_fix(seed) : lfsr_q));
        show_sym   = do_start ? gen_sym : seq_buf[step_d[AW-1:0]];
        leds_d     = (state_d == SHOW_ON) ? N_KEYS'(onehot(3'(show_sym))) : '0;
        points_sum = {1'b0, points_q} + 9'(level) + 9'd1;
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Counters, score and registered outputs.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            tcnt_q   <= '0;
            step_q   <= '0;
            round_q  <= '0;
            points_q <= '0;
            leds     <= '0;
            busy     <= 1'b0;
            win      <= 1'b0;
            lose     <= 1'b0;
        end else begin
            step_q <= step_d;

            // Tick timing restarts on every state change and on each correct
            // mid-round press, which is what restarts the timeout.
            if (state_d != state_q || restart) begin
                presc_q <= '0;
                tcnt_q  <= '0;
            end else if (tick) begin
                presc_q <= '0;
                tcnt_q  <= tcnt_q + TW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end

            if (do_start) begin
                round_q  <= RW'(1);
                points_q <= '0;
            end else begin
                if (adv_round) round_q <= round_q + RW'(1);
                if (round_done) begin
                    points_q <= (points_sum > 9'(POINTS_MAX)) ? POINTS_MAX : points_sum[7:0];
                end
            end

            leds <= leds_d;
            busy <= (state_d == SHOW_ON) || (state_d == SHOW_OFF) || (state_d == WAIT_USER);
            win  <= (state_d == WIN);
            lose <= (state_d == LOSE);
        end
    end

    // Sequence storage, contents only meaningful below the current round.
    always_ff @(posedge clock_50) begin
        if (do_start) begin
            seq_buf[0] <= gen_sym;
        end else if (adv_round) begin
            seq_buf[round_q[AW-1:0]] <= gen_sym;
        end
    end

    assign round     = round_q;
    assign points    = points_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_game_engine.sv
module tb_seq_game_engine;
    import seq_game_pkg::*;

    localparam int N_KEYS        = 4;
    localparam int MAX_ROUNDS    = 3;
    localparam int TICK_DIV      = 4;
    localparam int TIMEOUT_TICKS = 5;
    localparam int RW            = $clog2(MAX_ROUNDS + 1);

    logic              clock_50   = 1'b0;
    logic              reset      = 1'b1;
    logic              start      = 1'b0;
    logic [1:0]        level      = 2'd3;
    logic [7:0]        seed       = 8'h01;
    logic [RW-1:0]     max_rounds = RW'(2);
    logic [N_KEYS-1:0] key_pulse  = '0;
    logic [N_KEYS-1:0] leds;
    logic [RW-1:0]     round;
    logic [7:0]        points;
    logic              busy, win, lose;
    state_t            state_dbg;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  m_lfsr;
    logic [1:0]  m_sym[$];

    seq_game_engine #(
        .N_KEYS        (N_KEYS),
        .MAX_ROUNDS    (MAX_ROUNDS),
        .TICK_DIV      (TICK_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clock_50   (clock_50),
        .reset      (reset),
        .start      (start),
        .level      (level),
        .seed       (seed),
        .max_rounds (max_rounds),
        .key_pulse  (key_pulse),
        .leds       (leds),
        .round      (round),
        .points     (points),
        .busy       (busy),
        .win        (win),
        .lose       (lose),
        .state_dbg  (state_dbg)
    );

    // Clock and watchdog
    always #5 clock_50 = ~clock_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model of the symbol generator
    task automatic m_gen();
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_sym.push_back(m_lfsr[1:0]);
    endtask

    task automatic m_start(input logic [7:0] s);
        m_lfsr = (s == 8'h00) ? 8'h01 : s;
        m_sym.delete();
        m_gen();
    endtask

    function automatic logic [3:0] key_of(input logic [1:0] s);
        logic [3:0] k;
        k = 4'b0001;
        return k << s;
    endfunction

    // Driver tasks
    task automatic step_clk(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_50);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step_clk();
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        key_pulse = k;
        step_clk();
        key_pulse = '0;
    endtask

    // Scoreboard
    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_out(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%0h required=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%0h required=%0h", tag, obs, e);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push_exp(e);
        check_out(tag, obs);
    endtask

    task automatic wait_state(input state_t s, input int budget, input string tag);
        int n;
        n = 0;
        while (state_dbg !== s && n < budget) begin
            step_clk();
            n++;
        end
        if (state_dbg !== s) begin
            checks++;
            errors++;
            $error("FAIL %s: observed state=%s required state=%s (timeout)", tag, state_dbg.name(), s.name());
        end
    endtask

    // Cycles the current leds pattern stays on
    task automatic led_on_cycles(output int n);
        logic [3:0] on;
        on = leds;
        n = 0;
        while (leds === on && n < 100) begin
            n++;
            step_clk();
        end
    endtask

    // Follow the show of round r, checking each displayed symbol
    task automatic watch_show(input int r, input string tag);
        for (int i = 0; i < r; i++) begin
            wait_state(SHOW_ON, 100, tag);
            push_exp(32'(key_of(m_sym[i])));
            check_out($sformatf("%s_led%0d", tag, i), 32'(leds));
            wait_state(SHOW_OFF, 100, tag);
        end
        wait_state(WAIT_USER, 100, tag);
        expect_now($sformatf("%s_wait_leds", tag), 32'(leds), 0);
    endtask

    initial begin
        int n;

        // Reset state
        step_clk(2);
        expect_now("rst_leds",   32'(leds),      0);
        expect_now("rst_round",  32'(round),     0);
        expect_now("rst_points", 32'(points),    0);
        expect_now("rst_busy",   32'(busy),      0);
        expect_now("rst_win",    32'(win),       0);
        expect_now("rst_lose",   32'(lose),      0);
        expect_now("rst_state",  32'(state_dbg), 32'(IDLE));
        reset = 1'b0;
        step_clk(3);
        expect_now("idle_state", 32'(state_dbg), 32'(IDLE));

        // Win: seed 1, level 3, two rounds
        seed = 8'h01; level = 2'd3; max_rounds = RW'(2);
        m_start(seed);
        push_exp(32'(key_of(m_sym[0])));
        push_exp(1);
        push_exp(0);
        push_exp(1);
        pulse_start();
        check_out("win_r1_leds",   32'(leds));
        check_out("win_r1_round",  32'(round));
        check_out("win_r1_points", 32'(points));
        check_out("win_r1_busy",   32'(busy));
        led_on_cycles(n);
        expect_now("win_r1_on_cycles", n, 4);
        wait_state(WAIT_USER, 100, "win_r1_wait");
        expect_now("win_r1_wait_leds", 32'(leds), 0);
        press(key_of(m_sym[0]));
        m_gen();
        expect_now("win_r2_state",  32'(state_dbg), 32'(SHOW_ON));
        expect_now("win_r2_round",  32'(round),     2);
        expect_now("win_r2_points", 32'(points),    4);
        expect_now("win_r2_leds0",  32'(leds),      32'(key_of(m_sym[0])));
        pulse_start();
        expect_now("busy_start_ignored", 32'(round), 2);
        wait_state(SHOW_OFF, 100, "win_r2_off");
        wait_state(SHOW_ON, 100, "win_r2_on1");
        expect_now("win_r2_leds1", 32'(leds), 32'(key_of(m_sym[1])));
        wait_state(WAIT_USER, 100, "win_r2_wait");
        press(key_of(m_sym[0]));
        expect_now("win_mid_press_state", 32'(state_dbg), 32'(WAIT_USER));
        press(key_of(m_sym[1]));
        expect_now("win_flag",   32'(win),    1);
        expect_now("win_points", 32'(points), 8);
        expect_now("win_round",  32'(round),  2);
        expect_now("win_busy",   32'(busy),   0);
        press(4'b0100);
        step_clk(6);
        expect_now("win_held_state",  32'(state_dbg), 32'(WIN));
        expect_now("win_held_points", 32'(points),    8);

        // Wrong key in round 1
        m_start(seed);
        pulse_start();
        expect_now("wrong_win_cleared", 32'(win), 0);
        wait_state(WAIT_USER, 100, "wrong_wait");
        press(4'b0010);
        expect_now("wrong_lose",   32'(lose),   1);
        expect_now("wrong_points", 32'(points), 0);
        expect_now("wrong_round",  32'(round),  1);
        expect_now("wrong_busy",   32'(busy),   0);

        // Timeout
        m_start(seed);
        pulse_start();
        expect_now("timeout_lose_cleared", 32'(lose), 0);
        wait_state(WAIT_USER, 100, "timeout_wait");
        n = 0;
        while (lose !== 1'b1 && n < 100) begin
            step_clk();
            n++;
        end
        expect_now("timeout_cycles", n, 20);
        expect_now("timeout_state", 32'(state_dbg), 32'(LOSE));

        // Double key, level 2 (two ticks per phase)
        level = 2'd2;
        m_start(seed);
        pulse_start();
        led_on_cycles(n);
        expect_now("lvl2_on_cycles", n, 8);
        wait_state(WAIT_USER, 100, "double_wait");
        press(4'b0101);
        expect_now("double_lose",  32'(lose),  1);
        expect_now("double_round", 32'(round), 1);

        // Reset in the middle of round 2's show
        level = 2'd3;
        m_start(seed);
        pulse_start();
        wait_state(WAIT_USER, 100, "rst_mid_wait");
        press(key_of(m_sym[0]));
        step_clk();
        #2;
        reset = 1'b1;
        #1;
        expect_now("rst_mid_leds",   32'(leds),      0);
        expect_now("rst_mid_round",  32'(round),     0);
        expect_now("rst_mid_points", 32'(points),    0);
        expect_now("rst_mid_busy",   32'(busy),      0);
        expect_now("rst_mid_lose",   32'(lose),      0);
        expect_now("rst_mid_state",  32'(state_dbg), 32'(IDLE));
        step_clk();
        reset = 1'b0;
        step_clk();
        m_start(seed);
        pulse_start();
        expect_now("rst_replay_leds",  32'(leds),  32'(key_of(m_sym[0])));
        expect_now("rst_replay_round", 32'(round), 1);

        // max_rounds = 0 means MAX_ROUNDS (3)
        step_clk(2);
        max_rounds = '0;
        wait_state(LOSE, 300, "max0_prev_lose");
        m_start(seed);
        pulse_start();
        for (int r = 1; r <= 3; r++) begin
            watch_show(r, $sformatf("max0_r%0d", r));
            for (int i = 0; i < r; i++) press(key_of(m_sym[i]));
            if (r < 3) begin
                m_gen();
                expect_now($sformatf("max0_r%0d_next_round", r), 32'(round), 32'(r + 1));
            end
        end
        expect_now("max0_win",    32'(win),    1);
        expect_now("max0_points", 32'(points), 12);
        expect_now("max0_round",  32'(round),  3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
